dice_roller: RTL and testbench
==============================

Name: dice_roller

Overview:
Consumes the 6-bit LFSR state and turns it into two fair die faces (1..6) plus their sum for the craps game FSM. On a roll request it steps the LFSR by driving the LFSR's roll-enable input, then samples the register. It rejects out-of-range 3-bit fields, retries, and falls back to modulo mapping after a bounded number of retries. It sits between the LFSR and the game-rules controller.

Parameters:
ADV_STEPS, 6, LFSR shift cycles per attempt (6 gives fully fresh bits)
MAX_RETRY, 4, rejected attempts before modulo fallback (must be >=1)

Ports:
clock  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
roll_req  input  1  roll button level; a roll starts on its rising edge
lfsr_q  input  6  current LFSR state; die1 field = [2:0], die2 field = [5:3]
lfsr_adv  output  1  drives the LFSR roll-enable; high means shift this cycle
die1  output  3  first die face, 1..6
die2  output  3  second die face, 1..6
sum  output  4  die1+die2, 2..12
valid  output  1  one-cycle pulse when a new roll result is presented
busy  output  1  high from roll acceptance until the valid cycle, inclusive

Behaviour:
- Reset (async, any state): state=IDLE; die1=1, die2=1, sum=2; valid=0, busy=0, lfsr_adv=0; step and retry counters=0; roll_req edge register=0; both field-accepted flags cleared.
- Edge detect: req_d registers roll_req every cycle. A start occurs when roll_req=1, req_d=0 and state=IDLE. Edges seen in any other state are dropped, not queued.
- States:
  - IDLE -> ADVANCE on start. busy goes high the next cycle. Both accepted flags and the retry counter clear.
  - ADVANCE: lfsr_adv=1, decoded combinationally from state. Stays for exactly ADV_STEPS cycles, counted by the step counter. -> SAMPLE.
  - SAMPLE: lfsr_adv=0; lfsr_q is stable. For each field not yet accepted:
    - value 1..6: latch it into die1/die2 and set the accepted flag.
    - value 0 or 7: reject it.
    - If both flags are set -> DONE.
    - Else if retry+1 == MAX_RETRY: take each unaccepted field as (field mod 6)+1, so 0->1 and 7->2, then -> DONE.
    - Else retry++ -> ADVANCE.
  - DONE: valid=1 for one cycle, busy=1, sum=die1+die2 as registered. -> IDLE.
- die1, die2 and sum update only in SAMPLE and hold otherwise, including across later rejects. sum is registered together with the dice, so it is consistent with them in the valid cycle.
- Latency with both fields accepted first try: the start edge is registered at clock N. ADVANCE covers N+1..N+ADV_STEPS. SAMPLE is at N+ADV_STEPS+1. valid is high in the cycle after edge N+ADV_STEPS+2.
- Worst-case latency: MAX_RETRY*(ADV_STEPS+1)+1 cycles after the start edge.
- A field accepted in an early attempt is kept; later attempts evaluate only the other field.
- roll_req held high triggers only one roll. A new roll needs a low-then-high transition after returning to IDLE.
- Reset asserted mid-roll aborts immediately. lfsr_adv drops asynchronously and the outputs return to their reset values.
- The LFSR's own reset and seed are external to this block.
- Arithmetic: sum is a 4-bit unsigned add of two 3-bit operands; no overflow is possible. The mod-6 mapping is a pure function of the 3-bit field, implementable as a case table.

Decomposition:
- Shared craps package holds:
  - state encoding constants: IDLE, ADVANCE, SAMPLE, DONE.
  - die range constants DIE_MIN=1 and DIE_MAX=6.
  - the reset face value (1).
- One natural sub-module, die_field_map: combinational 3-bit field -> {in_range, direct face, mod6+1 face}, instantiated twice.
- The FSM, counters and registers stay in dice_roller.

Test Plan:
- Reset then idle with roll_req=0: die1=1, die2=1, sum=2, valid=0, busy=0, lfsr_adv=0; lfsr_adv never asserts.
- Roll with a bench LFSR model giving lfsr_q=6'b011_010 after 6 shifts: lfsr_adv high exactly 6 cycles, die1=2, die2=3, sum=5, valid pulses once at start+8.
- First sample 6'b000_101 (die2 field 0), second sample 6'b110_001: die1=5 kept from attempt 1, die2=6, sum=11, lfsr_adv total 12 cycles.
- Forced rejects: every sample 6'b111_000 for 4 attempts: fallback gives die1=1, die2=2, sum=3; valid after 4*(6+1)+1 cycles.
- roll_req held high 50 cycles, plus a second rising edge while busy: exactly one valid pulse; dice reflect only the first roll.
- rst asserted during the 3rd ADVANCE cycle: same-cycle lfsr_adv=0, busy=0, die1=1, die2=1, sum=2. No valid pulse follows; a fresh roll_req edge afterwards completes normally.

Source files
------------

// File: rtl/dice_roller_pkg.sv
// dice_roller_pkg
// Shared definitions for the craps dice roller: roll FSM state encoding,
// the legal die face range and the faces/sum presented out of reset.
package dice_roller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADVANCE = 2'd1,
    SAMPLE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [2:0] DIE_MIN    = 3'd1;
  localparam logic [2:0] DIE_MAX    = 3'd6;
  localparam logic [2:0] FACE_RESET = 3'd1;
  localparam logic [3:0] SUM_RESET  = 4'd2;

endpackage

// File: rtl/die_field_map.sv
// die_field_map
// Purely combinational view of one 3-bit LFSR field as a die face.
// Ports:
//   i_field    - raw 3-bit field taken from the LFSR state
//   o_in_range - field already is a legal face (1..6)
//   o_face     - the field used directly as a face (meaningful when in range)
//   o_mod_face - (field mod 6) + 1, always a legal face; the fallback mapping
module die_field_map (
  input  logic [2:0] i_field,
  output logic       o_in_range,
  output logic [2:0] o_face,
  output logic [2:0] o_mod_face
);
  import dice_roller_pkg::*;

  // Range check against the die limits, plus a lookup table for the
  // modulo fallback so no divider is inferred.
  always_comb begin
    o_in_range = (i_field >= DIE_MIN) && (i_field <= DIE_MAX);
    o_face     = i_field;
    o_mod_face = FACE_RESET;
    case (i_field)
      3'd0:    o_mod_face = 3'd1;
      3'd1:    o_mod_face = 3'd2;
      3'd2:    o_mod_face = 3'd3;
      3'd3:    o_mod_face = 3'd4;
      3'd4:    o_mod_face = 3'd5;
      3'd5:    o_mod_face = 3'd6;
      3'd6:    o_mod_face = 3'd1;
      default: o_mod_face = 3'd2;
    endcase
  end

endmodule

// File: rtl/dice_roller.sv
// dice_roller
// Turns the 6-bit LFSR state into two fair die faces and their sum.
// A roll steps the LFSR ADV_STEPS cycles, samples it, rejects out-of-range
// fields and retries; after MAX_RETRY attempts leftover fields are mapped mod 6.
// Ports:
//   clock    - system clock, rising edge
//   rst      - asynchronous active-high reset
//   roll_req - roll button level; a roll starts on its rising edge in IDLE
//   lfsr_q   - LFSR state; die1 field = [2:0], die2 field = [5:3]
//   lfsr_adv - LFSR shift enable, high for every ADVANCE cycle
//   die1     - first die face 1..6
//   die2     - second die face 1..6
//   sum      - die1 + die2, 2..12
//   valid    - one-cycle pulse presenting a new result
//   busy     - high from roll acceptance through the valid cycle
module dice_roller #(
  parameter int ADV_STEPS = 6,
  parameter int MAX_RETRY = 4
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       roll_req,
  input  logic [5:0] lfsr_q,
  output logic       lfsr_adv,
  output logic [2:0] die1,
  output logic [2:0] die2,
  output logic [3:0] sum,
  output logic       valid,
  output logic       busy
);
  import dice_roller_pkg::*;

  localparam int STEP_W  = (ADV_STEPS > 1) ? $clog2(ADV_STEPS) : 1;
  localparam int RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

  state_t               r_state;
  state_t               w_next;
  logic                 r_req_d;
  logic [STEP_W-1:0]    r_step;
  logic [RETRY_W-1:0]   r_retry;
  logic                 r_acc1;
  logic                 r_acc2;
  logic [2:0]           r_die1;
  logic [2:0]           r_die2;
  logic [3:0]           r_sum;

  logic                 w_start;
  logic                 w_step_last;
  logic                 w_retry_last;
  logic                 w_in1, w_in2;
  logic [2:0]           w_face1, w_face2;
  logic [2:0]           w_mod1, w_mod2;
  logic                 w_acc1_nxt, w_acc2_nxt;
  logic                 w_both;
  logic [2:0]           w_die1_nxt, w_die2_nxt;

  die_field_map u_map1 (
    .i_field    (lfsr_q[2:0]),
    .o_in_range (w_in1),
    .o_face     (w_face1),
    .o_mod_face (w_mod1)
  );

  die_field_map u_map2 (
    .i_field    (lfsr_q[5:3]),
    .o_in_range (w_in2),
    .o_face     (w_face2),
    .o_mod_face (w_mod2)
  );

  assign w_start      = roll_req && !r_req_d && (r_state == IDLE);
  assign w_step_last  = (r_step == STEP_W'(ADV_STEPS - 1));
  assign w_retry_last = (r_retry == RETRY_W'(MAX_RETRY - 1));

  // Sample-time decision: a field already accepted keeps its face; an
  // unaccepted one takes the direct face if legal, or the mod-6 face when
  // this was the last permitted attempt.
  always_comb begin
    w_acc1_nxt = r_acc1 || w_in1;
    w_acc2_nxt = r_acc2 || w_in2;
    w_both     = w_acc1_nxt && w_acc2_nxt;
    w_die1_nxt = r_die1;
    w_die2_nxt = r_die2;
    if (!r_acc1 && w_in1)
      w_die1_nxt = w_face1;
    else if (!w_acc1_nxt && w_retry_last)
      w_die1_nxt = w_mod1;
    if (!r_acc2 && w_in2)
      w_die2_nxt = w_face2;
    else if (!w_acc2_nxt && w_retry_last)
      w_die2_nxt = w_mod2;
  end

  // State register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic; the LFSR enable, valid and busy decode straight from
  // the state so a reset drops them without waiting for a clock.
  always_comb begin
    w_next   = r_state;
    lfsr_adv = 1'b0;
    valid    = 1'b0;
    busy     = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_start)
          w_next = ADVANCE;
      end
      ADVANCE: begin
        lfsr_adv = 1'b1;
        if (w_step_last)
          w_next = SAMPLE;
      end
      SAMPLE: begin
        if (w_both || w_retry_last)
          w_next = DONE;
        else
          w_next = ADVANCE;
      end
      DONE: begin
        valid  = 1'b1;
        w_next = IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = IDLE;
      end
    endcase
  end

  // Counters, accepted flags and the result registers. Dice and sum only
  // load in SAMPLE so the sum always matches the dice it is shown with.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_req_d <= 1'b0;
      r_step  <= '0;
      r_retry <= '0;
      r_acc1  <= 1'b0;
      r_acc2  <= 1'b0;
      r_die1  <= FACE_RESET;
      r_die2  <= FACE_RESET;
      r_sum   <= SUM_RESET;
    end else begin
      r_req_d <= roll_req;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_acc1  <= 1'b0;
            r_acc2  <= 1'b0;
            r_retry <= '0;
            r_step  <= '0;
          end
        end
        ADVANCE: begin
          r_step <= w_step_last ? '0 : r_step + STEP_W'(1);
        end
        SAMPLE: begin
          r_acc1 <= w_acc1_nxt;
          r_acc2 <= w_acc2_nxt;
          r_die1 <= w_die1_nxt;
          r_die2 <= w_die2_nxt;
          r_sum  <= {1'b0, w_die1_nxt} + {1'b0, w_die2_nxt};
          if (!w_both && !w_retry_last)
            r_retry <= r_retry + RETRY_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign die1 = r_die1;
  assign die2 = r_die2;
  assign sum  = r_sum;

endmodule

// File: tb/tb_dice_roller.sv
// tb_dice_roller
// Directed bench for dice_roller. A small LFSR stand-in presents a chosen
// value after every sixth shift of a roll; values in between are filler.
module tb_dice_roller;

  localparam int ADV = 6;

  logic       clock = 1'b0;
  logic       rst;
  logic       roll_req;
  logic [5:0] lfsr_q = 6'b100_100;
  logic       lfsr_adv;
  logic [2:0] die1;
  logic [2:0] die2;
  logic [3:0] sum;
  logic       valid;
  logic       busy;

  int testsRun;
  int testsFailed;

  logic [5:0] sampleTab [4];
  int phase     = 0;
  int totalAdv  = 0;
  int validSeen = 0;

  dice_roller #(.ADV_STEPS(6), .MAX_RETRY(4)) dut (
    .clock    (clock),
    .rst      (rst),
    .roll_req (roll_req),
    .lfsr_q   (lfsr_q),
    .lfsr_adv (lfsr_adv),
    .die1     (die1),
    .die2     (die2),
    .sum      (sum),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // LFSR stand-in: shifts when enabled, showing the next table entry after
  // each block of six shifts within a roll. Also counts enables and valids.
  always @(posedge clock) begin
    if (valid)
      validSeen <= validSeen + 1;
    if (lfsr_adv)
      totalAdv <= totalAdv + 1;
    if (!busy)
      phase <= 0;
    else if (lfsr_adv) begin
      phase <= phase + 1;
      if (((phase + 1) % ADV) == 0)
        lfsr_q <= sampleTab[((phase + 1) / ADV - 1) % 4];
      else
        lfsr_q <= 6'b100_100;
    end
  end

  // Raise roll_req and count rising edges (start edge included) until valid
  // is seen; bounded so a dead DUT cannot hang the run.
  task automatic doRoll(output int lat, output bit seen);
    @(negedge clock);
    roll_req = 1'b1;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      lat++;
      if (valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int advBase;
    @(negedge clock);
    testsRun++; if (die1 !== 3'd1) begin testsFailed++; $display("[TB] FAIL reset_die1 got %0d expected 1", die1); end
    testsRun++; if (die2 !== 3'd1) begin testsFailed++; $display("[TB] FAIL reset_die2 got %0d expected 1", die2); end
    testsRun++; if (sum !== 4'd2) begin testsFailed++; $display("[TB] FAIL reset_sum got %0d expected 2", sum); end
    testsRun++; if ({valid, busy, lfsr_adv} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_ctrl got %b expected 000", {valid, busy, lfsr_adv}); end
    rst = 1'b0;
    advBase = totalAdv;
    repeat (10) @(negedge clock);
    testsRun++; if (totalAdv !== advBase) begin testsFailed++; $display("[TB] FAIL idle_adv got %0d expected 0", totalAdv - advBase); end
    testsRun++; if ({valid, busy} !== 2'b00) begin testsFailed++; $display("[TB] FAIL idle_ctrl got %b expected 00", {valid, busy}); end
  endtask

  task automatic test_first_try;
    int lat; bit seen; int advBase; int vBase;
    sampleTab[0] = 6'b011_010;
    advBase = totalAdv;
    vBase = validSeen;
    doRoll(lat, seen);
    roll_req = 1'b0;
    testsRun++; if (seen !== 1'b1) begin testsFailed++; $display("[TB] FAIL first_valid got %0d expected 1", seen); end
    testsRun++; if (lat !== 8) begin testsFailed++; $display("[TB] FAIL first_latency got %0d expected 8", lat); end
    testsRun++; if (die1 !== 3'd2) begin testsFailed++; $display("[TB] FAIL first_die1 got %0d expected 2", die1); end
    testsRun++; if (die2 !== 3'd3) begin testsFailed++; $display("[TB] FAIL first_die2 got %0d expected 3", die2); end
    testsRun++; if (sum !== 4'd5) begin testsFailed++; $display("[TB] FAIL first_sum got %0d expected 5", sum); end
    testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL first_busy_valid got %0d expected 1", busy); end
    @(negedge clock);
    testsRun++; if ({valid, busy} !== 2'b00) begin testsFailed++; $display("[TB] FAIL first_after got %b expected 00", {valid, busy}); end
    repeat (3) @(negedge clock);
    testsRun++; if (totalAdv - advBase !== 6) begin testsFailed++; $display("[TB] FAIL first_adv_cycles got %0d expected 6", totalAdv - advBase); end
    testsRun++; if (validSeen - vBase !== 1) begin testsFailed++; $display("[TB] FAIL first_valid_count got %0d expected 1", validSeen - vBase); end
  endtask

  task automatic test_max_faces;
    int lat; bit seen;
    sampleTab[0] = 6'b110_110;
    doRoll(lat, seen);
    roll_req = 1'b0;
    testsRun++; if (seen !== 1'b1 || lat !== 8) begin testsFailed++; $display("[TB] FAIL max_latency got %0d expected 8", lat); end
    testsRun++; if ({die1, die2, sum} !== {3'd6, 3'd6, 4'd12}) begin testsFailed++; $display("[TB] FAIL max_result got %0d/%0d/%0d expected 6/6/12", die1, die2, sum); end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_retry_keep;
    int lat; bit seen; int advBase;
    sampleTab[0] = 6'b000_101;
    sampleTab[1] = 6'b110_001;
    advBase = totalAdv;
    doRoll(lat, seen);
    roll_req = 1'b0;
    testsRun++; if (seen !== 1'b1 || lat !== 15) begin testsFailed++; $display("[TB] FAIL retry_latency got %0d expected 15", lat); end
    testsRun++; if (die1 !== 3'd5) begin testsFailed++; $display("[TB] FAIL retry_die1_kept got %0d expected 5", die1); end
    testsRun++; if (die2 !== 3'd6) begin testsFailed++; $display("[TB] FAIL retry_die2 got %0d expected 6", die2); end
    testsRun++; if (sum !== 4'd11) begin testsFailed++; $display("[TB] FAIL retry_sum got %0d expected 11", sum); end
    repeat (3) @(negedge clock);
    testsRun++; if (totalAdv - advBase !== 12) begin testsFailed++; $display("[TB] FAIL retry_adv_cycles got %0d expected 12", totalAdv - advBase); end
  endtask

  task automatic test_fallback;
    int lat; bit seen; int advBase;
    for (int i = 0; i < 4; i++) sampleTab[i] = 6'b111_000;
    advBase = totalAdv;
    doRoll(lat, seen);
    roll_req = 1'b0;
    testsRun++; if (seen !== 1'b1 || lat !== 29) begin testsFailed++; $display("[TB] FAIL fallback_latency got %0d expected 29", lat); end
    testsRun++; if ({die1, die2, sum} !== {3'd1, 3'd2, 4'd3}) begin testsFailed++; $display("[TB] FAIL fallback_result got %0d/%0d/%0d expected 1/2/3", die1, die2, sum); end
    repeat (3) @(negedge clock);
    testsRun++; if (totalAdv - advBase !== 24) begin testsFailed++; $display("[TB] FAIL fallback_adv_cycles got %0d expected 24", totalAdv - advBase); end
  endtask

  task automatic test_held_request;
    int vBase; int advBase;
    sampleTab[0] = 6'b001_100;
    sampleTab[1] = 6'b110_110;
    vBase = validSeen;
    advBase = totalAdv;
    @(negedge clock);
    roll_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (i == 2) roll_req = 1'b0;
      if (i == 4) begin
        roll_req = 1'b1;
        testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL held_busy_midroll got %0d expected 1", busy); end
      end
    end
    testsRun++; if (validSeen - vBase !== 1) begin testsFailed++; $display("[TB] FAIL held_valid_count got %0d expected 1", validSeen - vBase); end
    testsRun++; if (totalAdv - advBase !== 6) begin testsFailed++; $display("[TB] FAIL held_adv_cycles got %0d expected 6", totalAdv - advBase); end
    testsRun++; if ({die1, die2, sum} !== {3'd4, 3'd1, 4'd5}) begin testsFailed++; $display("[TB] FAIL held_result got %0d/%0d/%0d expected 4/1/5", die1, die2, sum); end
    roll_req = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset_abort;
    int lat; bit seen; int vBase;
    sampleTab[0] = 6'b010_011;
    vBase = validSeen;
    @(negedge clock);
    roll_req = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    testsRun++; if (lfsr_adv !== 1'b1) begin testsFailed++; $display("[TB] FAIL abort_pre_adv got %0d expected 1", lfsr_adv); end
    rst = 1'b1;
    #1;
    testsRun++; if ({lfsr_adv, busy, valid} !== 3'b000) begin testsFailed++; $display("[TB] FAIL abort_ctrl got %b expected 000", {lfsr_adv, busy, valid}); end
    testsRun++; if ({die1, die2, sum} !== {3'd1, 3'd1, 4'd2}) begin testsFailed++; $display("[TB] FAIL abort_result got %0d/%0d/%0d expected 1/1/2", die1, die2, sum); end
    @(negedge clock);
    rst = 1'b0;
    roll_req = 1'b0;
    repeat (20) @(negedge clock);
    testsRun++; if (validSeen - vBase !== 0) begin testsFailed++; $display("[TB] FAIL abort_no_valid got %0d expected 0", validSeen - vBase); end
    doRoll(lat, seen);
    roll_req = 1'b0;
    testsRun++; if (seen !== 1'b1 || lat !== 8) begin testsFailed++; $display("[TB] FAIL abort_reroll_latency got %0d expected 8", lat); end
    testsRun++; if ({die1, die2, sum} !== {3'd3, 3'd2, 4'd5}) begin testsFailed++; $display("[TB] FAIL abort_reroll_result got %0d/%0d/%0d expected 3/2/5", die1, die2, sum); end
    repeat (3) @(negedge clock);
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    rst = 1'b1;
    roll_req = 1'b0;
    for (int i = 0; i < 4; i++) sampleTab[i] = 6'b010_001;
    repeat (2) @(negedge clock);
    test_reset;
    test_first_try;
    test_max_faces;
    test_retry_keep;
    test_fallback;
    test_held_request;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
